// File: rtl/plic_pkg.sv
// ----------------------------------------------------------------------------
// plic_pkg
// Shared definitions for the PLIC claim/complete sequencer:
//   - plic_state_e     : per-target claim FSM states (IDLE, PEND, INSVC)
//   - DEFER_W_DEFAULT  : default width of the per-target defer counter
// ----------------------------------------------------------------------------
package plic_pkg;

    localparam int DEFER_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        INSVC = 2'd2
    } plic_state_e;

endpackage

// File: rtl/plic_claim_fsm.sv
// ----------------------------------------------------------------------------
// plic_claim_fsm
// Claim/complete sequencer for one interrupt target. A claim read moves the
// target to PEND; the shared fence pulse then either accepts the claim (INSVC)
// or, if another target won the same id, discards it. A PEND that sees no
// fence for 2^DEFER_W-1 cycles times out and is discarded. A matching
// completion returns INSVC to IDLE.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   claim_re, claim_id  claim-register read strobe and presented id
//   complete_we,
//   complete_id         complete-register write strobe and written id
//   fence               core acceptance pulse (shared)
//   grant               this target wins arbitration for its pending id
//   pending             state == PEND (combinational, feeds arbitration)
//   latched_id          id held by this target
//   claim_fire          claim accepted this cycle (combinational)
//   busy                registered: target is PEND or INSVC
//   drop                registered one-cycle pulse: pending claim discarded
//   err                 registered one-cycle pulse: protocol violation
// ----------------------------------------------------------------------------
module plic_claim_fsm
    import plic_pkg::*;
#(
    parameter int N_SOURCE = 30,
    parameter int SRCW     = $clog2(N_SOURCE + 1),
    parameter int DEFER_W  = DEFER_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            claim_re,
    input  logic [SRCW-1:0] claim_id,
    input  logic            complete_we,
    input  logic [SRCW-1:0] complete_id,
    input  logic            fence,
    input  logic            grant,
    output logic            pending,
    output logic [SRCW-1:0] latched_id,
    output logic            claim_fire,
    output logic            busy,
    output logic            drop,
    output logic            err
);

    localparam logic [SRCW-1:0] MAX_ID = SRCW'(N_SOURCE);

    // The step that takes the counter to all-ones is the timeout step, so
    // the test is made one count earlier.
    localparam logic [DEFER_W-1:0] CNT_LAST = ~DEFER_W'(1);

    plic_state_e        state, state_next;
    logic [SRCW-1:0]    id_q, id_next;
    logic [DEFER_W-1:0] cnt_q, cnt_next;
    logic               busy_q, drop_q, err_q;
    logic               drop_next, err_next;

    logic claim_nz, claim_ok, claim_bad, compl_nz;

    assign claim_nz  = claim_re && (claim_id != '0);
    assign claim_ok  = claim_nz && (claim_id <= MAX_ID);
    assign claim_bad = claim_nz && (claim_id > MAX_ID);
    assign compl_nz  = complete_we && (complete_id != '0);

    always_comb begin
        state_next = state;
        id_next    = id_q;
        cnt_next   = cnt_q;
        drop_next  = 1'b0;
        err_next   = 1'b0;
        claim_fire = 1'b0;

        case (state)
            IDLE: begin
                if (claim_ok) begin
                    id_next    = claim_id;
                    cnt_next   = '0;
                    state_next = PEND;
                end
                if (claim_bad) begin
                    err_next = 1'b1;
                end
            end

            PEND: begin
                // Fence wins over both a re-claim and a timeout; a re-claim
                // in the fence cycle is lost and the old id is accepted.
                if (fence) begin
                    if (grant) begin
                        state_next = INSVC;
                        claim_fire = 1'b1;
                    end else begin
                        state_next = IDLE;
                        drop_next  = 1'b1;
                    end
                end else if (claim_ok) begin
                    id_next  = claim_id;
                    cnt_next = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_next   = cnt_q + 1'b1;
                    state_next = IDLE;
                    drop_next  = 1'b1;
                end else begin
                    cnt_next = cnt_q + 1'b1;
                end
                if (claim_bad) begin
                    err_next = 1'b1;
                end
            end

            INSVC: begin
                if (claim_nz) begin
                    err_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Completion is legal only from INSVC with the latched id; any
        // other nonzero completion is still forwarded but flagged.
        if (compl_nz) begin
            if ((state == INSVC) && (complete_id == id_q)) begin
                state_next = IDLE;
            end else begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            id_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            drop_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_next;
            id_q   <= id_next;
            cnt_q  <= cnt_next;
            busy_q <= (state_next != IDLE);
            drop_q <= drop_next;
            err_q  <= err_next;
        end
    end

    assign pending    = (state == PEND);
    assign latched_id = id_q;
    assign busy       = busy_q;
    assign drop       = drop_q;
    assign err        = err_q;

endmodule

// File: rtl/plic_claim_seq.sv
// ----------------------------------------------------------------------------
// plic_claim_seq
// Claim/complete sequencer for N_TARGET PLIC targets. Each target runs its own
// plic_claim_fsm; this level arbitrates equal ids at fence time (lowest
// target index wins) and produces the registered one-hot claim/complete
// pulses toward the gateways.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   claim_re_i         per-target claim read strobe
//   claim_id_i         per-target id presented at claim read
//   complete_we_i      per-target complete write strobe
//   complete_id_i      per-target id written at completion
//   fence_i            shared core acceptance pulse
//   claim_o            one-cycle claim pulse, bit k = source k+1
//   complete_o         one-cycle complete pulse, bit k = source k+1
//   busy_o             target in PEND or INSVC
//   drop_o             one-cycle pulse: pending claim discarded
//   err_o              one-cycle pulse: protocol violation
// ----------------------------------------------------------------------------
module plic_claim_seq
    import plic_pkg::*;
#(
    parameter int N_SOURCE = 30,
    parameter int N_TARGET = 2,
    parameter int SRCW     = $clog2(N_SOURCE + 1),
    parameter int DEFER_W  = DEFER_W_DEFAULT
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_TARGET-1:0]            claim_re_i,
    input  logic [N_TARGET-1:0][SRCW-1:0]  claim_id_i,
    input  logic [N_TARGET-1:0]            complete_we_i,
    input  logic [N_TARGET-1:0][SRCW-1:0]  complete_id_i,
    input  logic                           fence_i,
    output logic [N_SOURCE-1:0]            claim_o,
    output logic [N_SOURCE-1:0]            complete_o,
    output logic [N_TARGET-1:0]            busy_o,
    output logic [N_TARGET-1:0]            drop_o,
    output logic [N_TARGET-1:0]            err_o
);

    logic [N_TARGET-1:0]           pending;
    logic [N_TARGET-1:0][SRCW-1:0] latched_id;
    logic [N_TARGET-1:0]           claim_fire;
    logic [N_TARGET-1:0]           grant;
    logic [N_SOURCE-1:0]           claim_next, complete_next;
    logic [N_SOURCE-1:0]           claim_q, complete_q;

    for (genvar t = 0; t < N_TARGET; t++) begin : g_target
        plic_claim_fsm #(
            .N_SOURCE (N_SOURCE),
            .SRCW     (SRCW),
            .DEFER_W  (DEFER_W)
        ) u_fsm (
            .clk         (clk_i),
            .rst         (rst_i),
            .claim_re    (claim_re_i[t]),
            .claim_id    (claim_id_i[t]),
            .complete_we (complete_we_i[t]),
            .complete_id (complete_id_i[t]),
            .fence       (fence_i),
            .grant       (grant[t]),
            .pending     (pending[t]),
            .latched_id  (latched_id[t]),
            .claim_fire  (claim_fire[t]),
            .busy        (busy_o[t]),
            .drop        (drop_o[t]),
            .err         (err_o[t])
        );
    end

    // A pending target loses the grant if any lower-indexed target is
    // pending on the same id.
    always_comb begin
        grant = '1;
        for (int t = 0; t < N_TARGET; t++) begin
            for (int j = 0; j < N_TARGET; j++) begin
                if ((j < t) && pending[j] && (latched_id[j] == latched_id[t])) begin
                    grant[t] = 1'b0;
                end
            end
        end
    end

    // Id-to-one-hot decode; ids 0 and above N_SOURCE match no bit.
    always_comb begin
        claim_next    = '0;
        complete_next = '0;
        for (int t = 0; t < N_TARGET; t++) begin
            for (int k = 0; k < N_SOURCE; k++) begin
                if (claim_fire[t] && (latched_id[t] == SRCW'(k + 1))) begin
                    claim_next[k] = 1'b1;
                end
                if (complete_we_i[t] && (complete_id_i[t] == SRCW'(k + 1))) begin
                    complete_next[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            claim_q    <= '0;
            complete_q <= '0;
        end else begin
            claim_q    <= claim_next;
            complete_q <= complete_next;
        end
    end

    assign claim_o    = claim_q;
    assign complete_o = complete_q;

endmodule

// File: tb/tb_plic_claim_seq.sv
// ----------------------------------------------------------------------------
// tb_plic_claim_seq
// Directed self-checking bench for plic_claim_seq with default parameters
// (30 sources, 2 targets, 5-bit ids, 5-bit defer counter). Inputs change 1 ns
// after a rising edge and outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_plic_claim_seq;

    localparam int N_SOURCE = 30;
    localparam int N_TARGET = 2;
    localparam int SRCW     = 5;

    logic                          clk;
    logic                          rst;
    logic [N_TARGET-1:0]           claim_re;
    logic [N_TARGET-1:0][SRCW-1:0] claim_id;
    logic [N_TARGET-1:0]           complete_we;
    logic [N_TARGET-1:0][SRCW-1:0] complete_id;
    logic                          fence;
    logic [N_SOURCE-1:0]           claim;
    logic [N_SOURCE-1:0]           complete;
    logic [N_TARGET-1:0]           busy;
    logic [N_TARGET-1:0]           drop;
    logic [N_TARGET-1:0]           err;

    int checks = 0;
    int errors = 0;

    plic_claim_seq #(
        .N_SOURCE (N_SOURCE),
        .N_TARGET (N_TARGET),
        .SRCW     (SRCW),
        .DEFER_W  (5)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .claim_re_i    (claim_re),
        .claim_id_i    (claim_id),
        .complete_we_i (complete_we),
        .complete_id_i (complete_id),
        .fence_i       (fence),
        .claim_o       (claim),
        .complete_o    (complete),
        .busy_o        (busy),
        .drop_o        (drop),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        claim_re    = '0;
        claim_id    = '0;
        complete_we = '0;
        complete_id = '0;
        fence       = 1'b0;
    endtask

    // Present one cycle of stimulus, let the edge sample it, then go quiet.
    task automatic claim_one(input int t, input int id);
        claim_re[t] = 1'b1;
        claim_id[t] = SRCW'(id);
        tick(1);
        clear_inputs();
    endtask

    task automatic complete_one(input int t, input int id);
        complete_we[t] = 1'b1;
        complete_id[t] = SRCW'(id);
        tick(1);
        clear_inputs();
    endtask

    task automatic fence_one();
        fence = 1'b1;
        tick(1);
        clear_inputs();
    endtask

    logic seen;

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;

        checkOutput("reset_claim",    64'(claim),    64'h0);
        checkOutput("reset_complete", 64'(complete), 64'h0);
        checkOutput("reset_busy",     64'(busy),     64'h0);
        checkOutput("reset_drop",     64'(drop),     64'h0);
        checkOutput("reset_err",      64'(err),      64'h0);

        // Basic claim, fence three cycles later, completion.
        claim_one(0, 5);
        checkOutput("c5_busy_pend", 64'(busy),  64'h1);
        checkOutput("c5_no_claim",  64'(claim), 64'h0);
        tick(2);
        fence_one();
        checkOutput("c5_claim", 64'(claim), 64'h10);
        checkOutput("c5_busy",  64'(busy),  64'h1);
        checkOutput("c5_drop",  64'(drop),  64'h0);
        tick(1);
        checkOutput("c5_claim_pulse", 64'(claim), 64'h0);
        complete_one(0, 5);
        checkOutput("c5_complete", 64'(complete), 64'h10);
        checkOutput("c5_idle",     64'(busy),     64'h0);
        checkOutput("c5_err",      64'(err),      64'h0);
        tick(1);
        checkOutput("c5_complete_pulse", 64'(complete), 64'h0);

        // Timeout: drop 31 cycles after the claim edge.
        claim_one(1, 7);
        seen = 1'b0;
        for (int i = 0; i < 29; i++) begin
            tick(1);
            if (drop != 0 || claim != 0 || busy != 2'b10) seen = 1'b1;
        end
        tick(1);
        checkOutput("to_early", 64'(seen), 64'h0);
        checkOutput("to_still_busy", 64'(busy), 64'h2);
        tick(1);
        checkOutput("to_drop",  64'(drop),  64'h2);
        checkOutput("to_idle",  64'(busy),  64'h0);
        checkOutput("to_claim", 64'(claim), 64'h0);
        tick(1);
        checkOutput("to_drop_pulse", 64'(drop), 64'h0);

        // Equal ids on both targets: target 0 wins, target 1 dropped.
        claim_re    = 2'b11;
        claim_id[0] = 5'd3;
        claim_id[1] = 5'd3;
        tick(1);
        clear_inputs();
        checkOutput("arb_busy_pend", 64'(busy), 64'h3);
        fence_one();
        checkOutput("arb_claim", 64'(claim), 64'h4);
        checkOutput("arb_drop",  64'(drop),  64'h2);
        checkOutput("arb_busy",  64'(busy),  64'h1);
        complete_one(0, 3);
        checkOutput("arb_complete", 64'(complete), 64'h4);
        checkOutput("arb_idle",     64'(busy),     64'h0);

        // Fence on the timeout cycle: accepted, no drop.
        claim_one(0, 12);
        tick(30);
        checkOutput("ft_still_pend", 64'(busy), 64'h1);
        fence_one();
        checkOutput("ft_claim", 64'(claim), 64'h800);
        checkOutput("ft_drop",  64'(drop),  64'h0);
        checkOutput("ft_busy",  64'(busy),  64'h1);
        tick(1);
        checkOutput("ft_drop_late", 64'(drop), 64'h0);
        // Mismatched completion in service: forwarded, flagged, stays busy.
        complete_one(0, 13);
        checkOutput("mis_complete", 64'(complete), 64'h1000);
        checkOutput("mis_err",      64'(err),      64'h1);
        checkOutput("mis_busy",     64'(busy),     64'h1);
        complete_one(0, 12);
        checkOutput("ft_idle", 64'(busy), 64'h0);
        checkOutput("ft_err",  64'(err),  64'h0);

        // Completion while idle, then a claim of id 0.
        complete_one(0, 9);
        checkOutput("idle_complete", 64'(complete), 64'h100);
        checkOutput("idle_err",      64'(err),      64'h1);
        claim_one(0, 0);
        checkOutput("id0_busy", 64'(busy), 64'h0);
        checkOutput("id0_err",  64'(err),  64'h0);
        fence_one();
        checkOutput("id0_claim", 64'(claim), 64'h0);

        // Out-of-range id 31.
        claim_one(1, 31);
        checkOutput("oor_claim_err",  64'(err),  64'h2);
        checkOutput("oor_claim_busy", 64'(busy), 64'h0);
        complete_one(1, 31);
        checkOutput("oor_complete",     64'(complete), 64'h0);
        checkOutput("oor_complete_err", 64'(err),      64'h2);

        // Re-claim in PEND with fence in the same cycle: old id accepted.
        claim_one(0, 8);
        claim_re[0] = 1'b1;
        claim_id[0] = 5'd9;
        fence       = 1'b1;
        tick(1);
        clear_inputs();
        checkOutput("rc_claim", 64'(claim), 64'h80);
        // Claim while in service is an error and is ignored.
        claim_one(0, 6);
        checkOutput("insvc_claim_err",  64'(err),  64'h1);
        checkOutput("insvc_claim_busy", 64'(busy), 64'h1);
        complete_one(0, 8);
        checkOutput("rc_err",  64'(err),  64'h0);
        checkOutput("rc_idle", 64'(busy), 64'h0);

        // Re-claim in PEND without fence restarts the defer count.
        claim_one(1, 4);
        tick(20);
        claim_one(1, 10);
        tick(20);
        checkOutput("rl_no_drop", 64'(drop), 64'h0);
        checkOutput("rl_busy",    64'(busy), 64'h2);
        fence_one();
        checkOutput("rl_claim", 64'(claim), 64'h200);
        complete_one(1, 10);
        checkOutput("rl_idle", 64'(busy), 64'h0);

        // Reset while pending discards the claim.
        claim_one(0, 2);
        checkOutput("rst_pend_busy", 64'(busy), 64'h1);
        rst = 1'b1;
        fence = 1'b1;
        tick(1);
        rst = 1'b0;
        clear_inputs();
        checkOutput("rst_claim", 64'(claim), 64'h0);
        checkOutput("rst_busy",  64'(busy),  64'h0);
        checkOutput("rst_drop",  64'(drop),  64'h0);
        checkOutput("rst_err",   64'(err),   64'h0);
        fence_one();
        checkOutput("rst_late_claim", 64'(claim), 64'h0);
        checkOutput("rst_late_drop",  64'(drop),  64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/plic_claim_seq.md
PLIC_CLAIM_SEQ -- requirements
Module: plic_claim_seq

Interface
REQ-001 SHALL have parameter N_SOURCE, default 30, number of interrupt sources (ids 1..N_SOURCE).
REQ-002 SHALL have parameter N_TARGET, default 2, number of interrupt targets.
REQ-003 SHALL have parameter SRCW, default $clog2(N_SOURCE+1), width of a source id.
REQ-004 SHALL have parameter DEFER_W, default 5, width of the per-target defer counter.
REQ-005 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port claim_re_i  input  N_TARGET  per-target claim-register read strobe.
REQ-008 SHALL have port claim_id_i  input  N_TARGET x SRCW  id presented to each target at its claim read.
REQ-009 SHALL have port complete_we_i  input  N_TARGET  per-target complete-register write strobe.
REQ-010 SHALL have port complete_id_i  input  N_TARGET x SRCW  id written at completion.
REQ-011 SHALL have port fence_i  input  1  core acceptance (valid fence) pulse, shared by all targets.
REQ-012 SHALL have port claim_o  output  N_SOURCE  one-cycle claim pulse to gateway, bit k = source k+1.
REQ-013 SHALL have port complete_o  output  N_SOURCE  one-cycle complete pulse to gateway, bit k = source k+1.
REQ-014 SHALL have port busy_o  output  N_TARGET  target in PEND or INSVC.
REQ-015 SHALL have port drop_o  output  N_TARGET  one-cycle pulse: pending claim discarded.
REQ-016 SHALL have port err_o  output  N_TARGET  one-cycle pulse: protocol violation.

Function
REQ-017 SHALL run one FSM per target, states IDLE, PEND, INSVC; each holds latched id (SRCW) and defer counter (DEFER_W).
REQ-018 IDLE: claim_re_i with claim_id_i != 0 SHALL latch id, clear counter, go PEND; id 0 SHALL be ignored.
REQ-019 PEND: fence_i SHALL, if granted (REQ-022), go INSVC and pulse claim_o[id-1] the following cycle.
REQ-020 PEND without fence_i: counter SHALL increment; at all-ones it SHALL go IDLE and pulse drop_o next cycle (2^DEFER_W-1 cycles after entry).
REQ-021 PEND: new claim_re_i with nonzero id SHALL relatch id and clear counter; fence_i in same cycle SHALL accept the old id.
REQ-022 Two or more PEND targets with equal id at fence_i: lowest index SHALL be granted; others SHALL go IDLE and pulse drop_o.
REQ-023 fence_i SHALL take priority over timeout in the same cycle.
REQ-024 INSVC: complete_we_i with complete_id_i == latched id SHALL go IDLE.
REQ-025 INSVC: claim_re_i with nonzero id SHALL be ignored and pulse err_o.
REQ-026 Any complete_we_i with nonzero id, any state, SHALL pulse complete_o[id-1] next cycle; in IDLE/PEND or on mismatch it SHALL also pulse err_o.
REQ-027 Ids > N_SOURCE SHALL produce no claim_o/complete_o bit and SHALL pulse err_o.
REQ-028 claim_o/complete_o SHALL be registered OR of all targets' pulses, latency exactly 1 cycle.
REQ-029 busy_o SHALL be registered state decode (state != IDLE).

Reset
REQ-030 rst_i SHALL force all FSMs to IDLE, counters and latched ids to 0, all outputs to 0 on the next edge.
REQ-031 Reset mid-PEND/INSVC SHALL discard state without claim_o, complete_o or drop_o pulses.

Structure
REQ-032 plic_pkg SHALL hold the state enum (IDLE/PEND/INSVC) and DEFER_W default.
REQ-033 Per-target FSM SHALL be sub-module plic_claim_fsm, instantiated N_TARGET times; grant and OR logic at top.

Verification
REQ-034 Target0 claim_re id=5, fence_i 3 cycles later -> claim_o[4] one pulse at fence+1, busy_o[0]=1; complete id=5 -> complete_o[4] pulse, busy_o[0]=0.
REQ-035 Target1 claim id=7, no fence -> drop_o[1] pulse 31 cycles after entry, no claim_o, state IDLE.
REQ-036 Targets 0,1 both PEND id=3, fence_i -> only claim_o[2], target0 INSVC, drop_o[1] pulse.
REQ-037 fence_i coincides with count 31 -> claim accepted, no drop_o.
REQ-038 Target0 IDLE, complete id=9 -> complete_o[8] pulse and err_o[0]; claim id=0 -> no state change.
REQ-039 rst_i asserted while target0 PEND id=2 -> all outputs 0 next cycle, later fence_i yields no claim_o.
